// File: rtl/alu_mdu.sv
// ALU with an iterative multiply/divide unit and architectural HI/LO registers.
// Single-cycle ops answer one cycle after transfer; mult/div run WIDTH iterations.
module alu_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [1:0]       aluop,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             zero,
  output logic             overflow,
  output logic             illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             md_done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] COUNT_START = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      count;
  logic               accept;

  logic [WIDTH-1:0]   sum, diff;
  logic               add_ovf, sub_ovf;
  logic [WIDTH-1:0]   dec_res;
  logic               dec_ovf, dec_ill;
  logic               start_mul, start_div, start_md, md_signed;
  logic [WIDTH-1:0]   abs_a, abs_b;

  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     mul_add, mul_sum;
  logic [2*WIDTH-1:0] prod_next, mul_final;

  logic [WIDTH-1:0]   dvsr, quo, rem, dvd;
  logic               div_zero, neg_res, neg_rem;
  logic [WIDTH:0]     rem_shift, rem_trial;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_next, quo_next, lo_div, hi_div;

  assign accept   = valid_i && ready_o;
  assign start_md = start_mul || start_div;

  assign sum     = a + b;
  assign diff    = a - b;
  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

  // Operation decode: single-cycle result plus mult/div launch requests.
  always_comb begin
    dec_res   = '0;
    dec_ovf   = 1'b0;
    dec_ill   = 1'b0;
    start_mul = 1'b0;
    start_div = 1'b0;
    md_signed = 1'b0;
    case (aluop)
      2'b00: begin dec_res = sum;  dec_ovf = add_ovf; end
      2'b01: begin dec_res = diff; dec_ovf = sub_ovf; end
      2'b10: begin
        case (funct)
          6'b100000: begin dec_res = sum;  dec_ovf = add_ovf; end
          6'b100001: dec_res = sum;
          6'b100010: begin dec_res = diff; dec_ovf = sub_ovf; end
          6'b100011: dec_res = diff;
          6'b100100: dec_res = a & b;
          6'b100101: dec_res = a | b;
          6'b100110: dec_res = a ^ b;
          6'b100111: dec_res = ~(a | b);
          6'b101010: dec_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
          6'b101011: dec_res = {{(WIDTH-1){1'b0}}, (a < b)};
          6'b010000: dec_res = hi;
          6'b010010: dec_res = lo;
          6'b011000: begin start_mul = 1'b1; md_signed = 1'b1; end
          6'b011001: start_mul = 1'b1;
          6'b011010: begin start_div = 1'b1; md_signed = 1'b1; end
          6'b011011: start_div = 1'b1;
          default:   dec_ill = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
  end

  // Signed ops iterate on magnitudes and fix the sign on the final edge.
  assign abs_a = (md_signed && a[WIDTH-1]) ? -a : a;
  assign abs_b = (md_signed && b[WIDTH-1]) ? -b : b;

  assign mul_add   = prod[0] ? {1'b0, mcand} : '0;
  assign mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + mul_add;
  assign prod_next = {mul_sum, prod[WIDTH-1:1]};
  assign mul_final = neg_res ? -prod_next : prod_next;

  assign rem_shift = {rem, quo[WIDTH-1]};
  assign rem_trial = rem_shift - {1'b0, dvsr};
  assign div_ge    = !rem_trial[WIDTH];
  assign rem_next  = div_ge ? rem_trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  assign quo_next  = {quo[WIDTH-2:0], div_ge};
  assign lo_div    = div_zero ? '1  : (neg_res ? -quo_next : quo_next);
  assign hi_div    = div_zero ? dvd : (neg_rem ? -rem_next : rem_next);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: flush wins over the final iteration.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && start_mul)      state_nxt = MUL;
        else if (accept && start_div) state_nxt = DIV;
      end
      MUL, DIV: begin
        if (flush || count == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake output.
  always_comb begin
    ready_o = (state == IDLE) && !rst;
  end

  // Datapath: single-cycle results, iteration registers and HI/LO.
  always_ff @(posedge clk) begin
    if (rst) begin
      count        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      zero         <= 1'b0;
      overflow     <= 1'b0;
      illegal      <= 1'b0;
      md_done      <= 1'b0;
      hi           <= '0;
      lo           <= '0;
      mcand        <= '0;
      prod         <= '0;
      dvsr         <= '0;
      quo          <= '0;
      rem          <= '0;
      dvd          <= '0;
      div_zero     <= 1'b0;
      neg_res      <= 1'b0;
      neg_rem      <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      zero         <= 1'b0;
      overflow     <= 1'b0;
      illegal      <= 1'b0;
      md_done      <= 1'b0;
      if (accept && !start_md) begin
        result       <= dec_res;
        result_valid <= 1'b1;
        zero         <= (dec_res == '0);
        overflow     <= dec_ovf;
        illegal      <= dec_ill;
      end
      if (accept && start_md) begin
        count    <= COUNT_START;
        mcand    <= abs_b;
        prod     <= {{WIDTH{1'b0}}, abs_a};
        dvsr     <= abs_b;
        quo      <= abs_a;
        rem      <= '0;
        dvd      <= a;
        div_zero <= (b == '0);
        neg_res  <= md_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_rem  <= md_signed && a[WIDTH-1];
      end
      if (state == MUL && !flush) begin
        prod <= prod_next;
        if (count != '0) begin
          count <= count - 1'b1;
        end else begin
          {hi, lo} <= mul_final;
          md_done  <= 1'b1;
        end
      end
      if (state == DIV && !flush) begin
        rem <= rem_next;
        quo <= quo_next;
        if (count != '0) begin
          count <= count - 1'b1;
        end else begin
          hi      <= hi_div;
          lo      <= lo_div;
          md_done <= 1'b1;
        end
      end
      if ((state == MUL || state == DIV) && flush) begin
        count <= '0;
      end
    end
  end

endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, datapath width; legal range 8..64, even values only.
REQ-002 SHALL provide port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL provide port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL provide port valid_i  input  1  operation request.
REQ-005 SHALL provide port ready_o  output  1  block can accept; = (state==IDLE) && !rst.
REQ-006 SHALL provide port aluop  input  2  00 add, 01 sub, 10 decode funct, 11 reserved.
REQ-007 SHALL provide port funct  input  6  R-type function field.
REQ-008 SHALL provide ports a, b  input  WIDTH  operands (rs, rt).
REQ-009 SHALL provide port flush  input  1  abort in-flight multiply/divide.
REQ-010 SHALL provide port result  output  WIDTH  registered result.
REQ-011 SHALL provide port result_valid  output  1  one-cycle pulse qualifying result, zero, overflow, illegal.
REQ-012 SHALL provide ports zero, overflow, illegal  output  1 each  result==0; signed add/sub overflow; undecodable op.
REQ-013 SHALL provide ports hi, lo  output  WIDTH  architectural HI/LO registers.
REQ-014 SHALL provide port md_done  output  1  one-cycle pulse when HI/LO updated by mult/div.

Function
REQ-015 Transfer SHALL occur only on a clk edge with valid_i && ready_o; inputs are ignored otherwise.
REQ-016 Single-cycle ops SHALL drive result and result_valid=1 exactly 1 cycle after transfer; result_valid=0 in all other cycles.
REQ-017 Decode, aluop=10: 100000 add, 100001 addu, 100010 sub, 100011 subu, 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt (signed), 101011 sltu, 010000 mfhi, 010010 mflo, 011000 mult, 011001 multu, 011010 div, 011011 divu.
REQ-018 Arithmetic SHALL wrap modulo 2^WIDTH; slt/sltu SHALL yield 0 or 1 zero-extended.
REQ-019 overflow SHALL be 1 only for add/sub (aluop 00/01, funct add/sub) on signed overflow; result is still written; addu/subu never flag.
REQ-020 Unlisted funct, or aluop=11, SHALL give result=0, illegal=1, result_valid=1 after 1 cycle, HI/LO unchanged.
REQ-021 FSM states SHALL be IDLE, MUL, DIV; mult/multu accepted in IDLE -> MUL, div/divu -> DIV.
REQ-022 MUL/DIV SHALL iterate exactly WIDTH cycles (counter WIDTH-1 down to 0; iterative shift-add multiply, restoring divide), then in the next cycle write HI/LO, pulse md_done, and return to IDLE; ready_o returns high in that same cycle (first acceptance WIDTH+1 edges after the start edge).
REQ-023 Mult: {hi,lo} SHALL equal the full 2*WIDTH-bit product (signed for mult, unsigned for multu).
REQ-024 Div: lo=quotient, hi=remainder, truncating toward zero, remainder sign = dividend sign.
REQ-025 Divide by zero SHALL give lo=all ones, hi=a, after the normal WIDTH-cycle latency.
REQ-026 Signed div of most-negative by -1 SHALL give lo=most-negative, hi=0.
REQ-027 Mult/div SHALL produce no result_valid pulse; result holds its prior value.
REQ-028 mfhi/mflo SHALL return hi/lo as of the transfer edge, including a value written by md_done in the preceding cycle.
REQ-029 flush in MUL/DIV SHALL return to IDLE at the next edge with HI/LO unchanged and no md_done; flush in IDLE SHALL be ignored.
REQ-030 flush and the final-iteration edge coinciding SHALL give flush priority: no HI/LO write, no md_done.

Reset
REQ-031 With rst high at an edge: state=IDLE, counter=0, result=0, hi=lo=0, result_valid=zero=overflow=illegal=md_done=0; ready_o=0 while rst is high.
REQ-032 rst mid-MUL/DIV SHALL abandon the operation and clear HI/LO; ready_o=1 in the first cycle after rst falls.

Verification
REQ-033 add a=0x7FFFFFFF, b=1 -> 1 cycle later result=0x80000000, overflow=1, zero=0, result_valid=1.
REQ-034 sub a=5, b=5 -> result=0, zero=1; sltu a=0xFFFFFFFF, b=1 -> 0; slt same operands -> 1.
REQ-035 mult a=0xFFFFFFFF (-1), b=2 -> ready_o low 32 cycles, md_done at edge 33, hi=0xFFFFFFFF, lo=0xFFFFFFFE; then mflo -> 0xFFFFFFFE.
REQ-036 div a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu a=9, b=0 -> lo=0xFFFFFFFF, hi=9.
REQ-037 multu started with hi=lo=0x1234, flush at cycle 10 -> IDLE next cycle, no md_done, hi=lo=0x1234; rst at cycle 10 of a div -> hi=lo=0, ready_o=1 the cycle after rst falls.
REQ-038 aluop=11 and funct=111111 -> illegal=1, result=0, result_valid=1; valid_i asserted while busy -> ignored, no extra result_valid.
